// File: rtl/audio_i2s_transmitter_if.sv
// Ready/valid sample stream from the audio FIFO into the I2S transmitter.
interface audio_i2s_transmitter_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] sink_data;
  logic              sink_valid;
  logic              sink_ready;

  modport master (output sink_data, output sink_valid, input  sink_ready);
  modport slave  (input  sink_data, input  sink_valid, output sink_ready);
endinterface

// File: rtl/audio_i2s_transmitter.sv
// I2S transmitter: one-entry sample buffer feeding a BCLK/LRCLK/SDATA serializer that
// repeats each sample in both slots of a frame and flags underrun at frame start.
module audio_i2s_transmitter #(
  parameter int BCLK_DIV  = 8,
  parameter int SLOT_BITS = 32,
  parameter int DATA_W    = 16
)(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  audio_i2s_transmitter_if.slave sink,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   sdata,
  output logic                   underrun,
  output logic [15:0]            underrun_count
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int KW = $clog2(SLOT_BITS);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [DW-1:0]     div_cnt;
  logic [KW-1:0]     slot_bit;
  logic              started;
  logic              buf_full, ready_q;
  logic [DATA_W-1:0] buf_q, active;

  logic              hs, fall, frame_start, take, buf_full_next, nxt_lr, nxt_sd;
  logic [KW-1:0]     nxt_bit, bit_idx;
  logic [DATA_W-1:0] sh;

  assign sink.sink_ready = ready_q;

  // slot_bit/lrclk together form the frame bit counter; the first falling edge
  // after entering RUN lands on bit 0 rather than advancing.
  always_comb begin
    hs   = sink.sink_valid & ready_q;
    fall = (state == RUN) && enable && (div_cnt == DW'(BCLK_DIV - 1)) && bclk;
    if (!started) begin
      nxt_bit = '0;
      nxt_lr  = 1'b0;
    end else if (slot_bit == KW'(SLOT_BITS - 1)) begin
      nxt_bit = '0;
      nxt_lr  = ~lrclk;
    end else begin
      nxt_bit = slot_bit + 1'b1;
      nxt_lr  = lrclk;
    end
    frame_start   = fall && (nxt_bit == '0) && !nxt_lr;
    take          = frame_start && buf_full;
    buf_full_next = hs ? 1'b1 : (take ? 1'b0 : buf_full);
    // Slot bit 0 is the one-bit delay, so the active sample is stable whenever it is read.
    bit_idx = KW'(DATA_W) - nxt_bit;
    sh      = active >> bit_idx;
    nxt_sd  = (nxt_bit != '0) && (nxt_bit <= KW'(DATA_W)) && sh[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full <= 1'b0;
      ready_q  <= 1'b0;
      buf_q    <= '0;
    end else begin
      buf_full <= buf_full_next;
      ready_q  <= !buf_full_next;
      if (hs) buf_q <= sink.sink_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bclk           <= 1'b0;
      lrclk          <= 1'b0;
      sdata          <= 1'b0;
      div_cnt        <= '0;
      slot_bit       <= '0;
      started        <= 1'b0;
      active         <= '0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      underrun <= 1'b0;
      if (state == IDLE || !enable) begin
        // Idle or leaving RUN: pins low, frame restarts at left slot bit 0 next time.
        state    <= enable ? RUN : IDLE;
        bclk     <= 1'b0;
        lrclk    <= 1'b0;
        sdata    <= 1'b0;
        div_cnt  <= '0;
        slot_bit <= '0;
        started  <= 1'b0;
      end else begin
        if (div_cnt == DW'(BCLK_DIV - 1)) begin
          div_cnt <= '0;
          bclk    <= ~bclk;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (fall) begin
          slot_bit <= nxt_bit;
          lrclk    <= nxt_lr;
          started  <= 1'b1;
          sdata    <= nxt_sd;
          if (frame_start) begin
            if (buf_full) begin
              active <= buf_q;
            end else begin
              active   <= '0;
              underrun <= 1'b1;
              if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_i2s_transmitter.sv
// Scoreboard bench: accepted samples are queued; the monitor advances a cycle-count
// model of the I2S frame and checks every pin each clock.
module tb_audio_i2s_transmitter;
  localparam int D = 8, S = 32, W = 16;

  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
  always #5 clk = ~clk;

  audio_i2s_transmitter_if #(.DATA_W(W)) sink_if();
  logic        bclk, lrclk, sdata, underrun;
  logic [15:0] underrun_count;

  audio_i2s_transmitter #(.BCLK_DIV(D), .SLOT_BITS(S), .DATA_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sink(sink_if.slave),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun),
    .underrun_count(underrun_count)
  );

  int vectors = 0, miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic force_evt = 1'b0;
  int mode = 0;
  logic [W-1:0] cnt_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the frame derived purely from clocks since entry.
  logic         pv_rst = 1'b0, pv_en = 1'b0, pv_hs = 1'b0;
  logic [W-1:0] pv_data = '0;
  logic         m_run = 1'b0;
  int           m_n = 0, m_cnt = 0;
  logic [W-1:0] m_cur = '0;

  always @(negedge clk) begin
    logic e_bclk, e_lr, e_sd, e_ur;
    int b, k;
    if (!reset_n || !pv_rst) begin
      m_run = 1'b0; m_n = 0; m_cur = '0; m_cnt = 0;
      exp_q.delete();
      check("reset_pins", {bclk, lrclk, sdata, underrun, sink_if.sink_ready, underrun_count}, 32'd0);
    end else begin
      e_ur = 1'b0;
      if (!m_run) begin
        if (pv_en) begin m_run = 1'b1; m_n = 0; end
      end else if (!pv_en) begin
        m_run = 1'b0;
      end else begin
        m_n++;
        if (m_n % (2*D) == 0 && ((m_n / (2*D) - 1) % (2*S)) == 0) begin
          if (exp_q.size() > 0) m_cur = exp_q.pop_front();
          else begin
            m_cur = '0; e_ur = 1'b1;
            if (m_cnt < 16'hFFFF) m_cnt++;
          end
        end
      end
      if (pv_hs) exp_q.push_back(pv_data);
      if (force_evt) begin m_cnt = 16'hFFFE; force_evt = 1'b0; end
      e_bclk = m_run ? ((m_n / D) % 2 == 1) : 1'b0;
      e_lr = 1'b0; e_sd = 1'b0;
      if (m_run && m_n >= 2*D) begin
        b = (m_n / (2*D) - 1) % (2*S);
        k = b % S;
        e_lr = (b >= S);
        e_sd = (k >= 1 && k <= W) ? m_cur[W-k] : 1'b0;
      end
      check("i2s_pins", {bclk, lrclk, sdata, underrun}, {e_bclk, e_lr, e_sd, e_ur});
      check("sink_ready", sink_if.sink_ready, exp_q.size() == 0);
      check("underrun_count", underrun_count, m_cnt);
    end
    pv_rst  = reset_n;
    pv_en   = enable;
    pv_hs   = sink_if.sink_valid && sink_if.sink_ready;
    pv_data = sink_if.sink_data;
  end

  // Producer: 0 idle, 1 held-valid counting data, 2 random, 3 one-shot.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      logic hs;
      hs = sink_if.sink_valid && sink_if.sink_ready;
      @(posedge clk); #1;
      case (mode)
        0: sink_if.sink_valid = 1'b0;
        1: begin
          if (hs) cnt_data++;
          sink_if.sink_valid = 1'b1;
          sink_if.sink_data  = cnt_data;
        end
        2: if (!sink_if.sink_valid || hs) begin
          sink_if.sink_valid = ($urandom_range(0, 3) != 0);
          sink_if.sink_data  = W'($urandom);
        end
        default: if (hs) sink_if.sink_valid = 1'b0;
      endcase
    end
  endtask

  initial begin
    sink_if.sink_valid = 1'b0;
    sink_if.sink_data  = '0;
    tick(3);
    reset_n = 1'b1;
    #1 check("ready_before_edge", sink_if.sink_ready, 1'b0);
    tick(1);
    check("ready_after_release", sink_if.sink_ready, 1'b1);

    // Single sample A5F0, then underrun frame.
    sink_if.sink_data = 16'hA5F0; sink_if.sink_valid = 1'b1; mode = 3;
    enable = 1'b1;
    tick(1100);

    // Continuous supply: one sample per frame, in order.
    mode = 1;
    tick(3200);

    // Reset mid-frame: pins drop immediately.
    tick(300);
    reset_n = 1'b0; mode = 0;
    #1 check("async_reset", {bclk, lrclk, sdata, underrun, sink_if.sink_ready, underrun_count}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("ready_post_reset", sink_if.sink_ready, 1'b1);

    // Starved: three frame starts, three underruns.
    tick(16 + 2048 + 100);
    check("underrun_x3", underrun_count, 16'd3);

    // Disable at bit 40 with a sample buffered, then resume.
    mode = 1;
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(1 + 656);
    enable = 1'b0;
    tick(1);
    check("disable_pins", {bclk, lrclk, sdata}, 3'b000);
    tick(20);
    enable = 1'b1;
    tick(1100);

    // Saturation of the underrun counter.
    mode = 0;
    tick(5);
    force dut.underrun_count = 16'hFFFE;
    force_evt = 1'b1;
    #1 release dut.underrun_count;
    tick(4300);
    check("underrun_sat", underrun_count, 16'hFFFF);

    // Random traffic and enable toggling.
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    mode = 2;
    for (int r = 0; r < 12; r++) begin
      enable = ($urandom_range(0, 3) != 0);
      tick($urandom_range(20, 2500));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
